// File: rtl/cnn_layer_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: state encoding, memory-select
// codes and the step-ordering helpers used by the top-level FSM.
package cnn_layer_seq_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StConv = 3'd1,
        StPool = 3'd2,
        StFlat = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } state_e;

    // Memory-select codes, also used by the convolution and max-pool engines.
    localparam logic [2:0] CselNone = 3'b000;
    localparam logic [2:0] CselL0K0 = 3'b001;
    localparam logic [2:0] CselL0K1 = 3'b010;
    localparam logic [2:0] CselL1K0 = 3'b011;
    localparam logic [2:0] CselL1K1 = 3'b100;
    localparam logic [2:0] CselL2   = 3'b101;

    localparam int unsigned WdWidth = 16;

    typedef struct packed {
        state_e state;
        logic   kernel;
    } step_t;

    // Step that follows 'cur' once its done pulse has been accepted.
    function automatic step_t next_step(step_t cur, int unsigned num_kernels);
        step_t nxt;
        nxt.state  = StIdle;
        nxt.kernel = 1'b0;
        case (cur.state)
            StConv: begin
                if (num_kernels > 1 && !cur.kernel) begin
                    nxt.state  = StConv;
                    nxt.kernel = 1'b1;
                end else begin
                    nxt.state = StPool;
                end
            end
            StPool: begin
                if (num_kernels > 1 && !cur.kernel) begin
                    nxt.state  = StPool;
                    nxt.kernel = 1'b1;
                end else begin
                    nxt.state = StFlat;
                end
            end
            StFlat:  nxt.state = StDone;
            default: nxt.state = StIdle;
        endcase
        return nxt;
    endfunction

    // Memory select presented while in step 's'.
    function automatic logic [2:0] csel_code(step_t s);
        logic [2:0] code;
        case (s.state)
            StConv:  code = s.kernel ? CselL0K1 : CselL0K0;
            StPool:  code = s.kernel ? CselL1K1 : CselL1K0;
            StFlat:  code = CselL2;
            default: code = CselNone;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/step_watchdog.sv
// Step watchdog: counts cycles spent waiting for a step-done pulse and flags
// expiry when the count reaches TIMEOUT. TIMEOUT of zero disables it.
module step_watchdog
    import cnn_layer_seq_pkg::*;
#(
    parameter logic [WdWidth-1:0] TIMEOUT = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WdWidth-1:0] cnt_q;

    // Wait counter: cleared on step entry, saturating increment while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != {WdWidth{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry decode, consumed by the sequencer's next-state logic.
    always_comb begin
        expired = (TIMEOUT != '0) && (cnt_q == TIMEOUT);
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer: walks conv/pool steps per kernel, then flatten, issuing
// one-cycle start pulses and waiting for matching done pulses. A watchdog moves
// the sequencer into a sticky error state if a step never completes.
module cnn_layer_seq
    import cnn_layer_seq_pkg::*;
#(
    parameter int unsigned        NUM_KERNELS = 2,
    parameter logic [WdWidth-1:0] TIMEOUT     = 16'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    output logic       busy,
    output logic       conv_start,
    input  logic       conv_done,
    output logic       pool_start,
    input  logic       pool_done,
    output logic       flat_start,
    input  logic       flat_done,
    output logic       kernel_sel,
    output logic [2:0] csel,
    output logic       err
);

    state_e     state_q;
    logic       kernel_q;
    logic       busy_q;
    logic       err_q;
    logic [2:0] csel_q;
    logic       conv_start_q;
    logic       pool_start_q;
    logic       flat_start_q;

    logic  in_step;
    logic  start_any;
    logic  done_match;
    logic  done_accept;
    logic  begin_job;
    logic  step_enter;
    logic  wd_expired;
    step_t cur;
    step_t nxt;

    // Decode which done pulse is relevant and whether it is accepted; a done in
    // the start-pulse cycle belongs to no step yet and is dropped.
    always_comb begin
        in_step    = (state_q == StConv) || (state_q == StPool) || (state_q == StFlat);
        start_any  = conv_start_q | pool_start_q | flat_start_q;
        done_match = 1'b0;
        case (state_q)
            StConv:  done_match = conv_done;
            StPool:  done_match = pool_done;
            StFlat:  done_match = flat_done;
            default: done_match = 1'b0;
        endcase
        done_accept = in_step && !start_any && done_match;
        begin_job   = (state_q == StIdle) && ready;
        step_enter  = begin_job || done_accept;
    end

    // Next step selection; an accepted done takes priority over watchdog expiry.
    always_comb begin
        cur.state  = state_q;
        cur.kernel = kernel_q;
        nxt        = cur;
        if (begin_job) begin
            nxt.state  = StConv;
            nxt.kernel = 1'b0;
        end else if (done_accept) begin
            nxt = next_step(cur, NUM_KERNELS);
        end else if (in_step && wd_expired) begin
            nxt.state  = StErr;
            nxt.kernel = 1'b0;
        end else if (state_q == StDone) begin
            nxt.state  = StIdle;
            nxt.kernel = 1'b0;
        end
    end

    // Sequencer state and registered outputs, all derived from the next step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            kernel_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            csel_q       <= CselNone;
            conv_start_q <= 1'b0;
            pool_start_q <= 1'b0;
            flat_start_q <= 1'b0;
        end else begin
            state_q      <= nxt.state;
            kernel_q     <= nxt.kernel;
            busy_q       <= (nxt.state == StConv) || (nxt.state == StPool) ||
                            (nxt.state == StFlat) || (nxt.state == StDone);
            err_q        <= (nxt.state == StErr);
            csel_q       <= csel_code(nxt);
            conv_start_q <= step_enter && (nxt.state == StConv);
            pool_start_q <= step_enter && (nxt.state == StPool);
            flat_start_q <= step_enter && (nxt.state == StFlat);
        end
    end

    step_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_step_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (step_enter),
        .en      (in_step),
        .expired (wd_expired)
    );

    assign busy       = busy_q;
    assign err        = err_q;
    assign csel       = csel_q;
    assign kernel_sel = kernel_q;
    assign conv_start = conv_start_q;
    assign pool_start = pool_start_q;
    assign flat_start = flat_start_q;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Bench for cnn_layer_seq: two instances (two kernels with an 8-cycle watchdog,
// one kernel with no watchdog) driven by randomized done latencies and noise.
module tb_cnn_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       ready      [2];
    logic       conv_done  [2];
    logic       pool_done  [2];
    logic       flat_done  [2];
    logic       busy       [2];
    logic       conv_start [2];
    logic       pool_start [2];
    logic       flat_start [2];
    logic       kernel_sel [2];
    logic       err        [2];
    logic [2:0] csel       [2];

    int total = 0;
    int bad   = 0;
    int lat [5];

    cnn_layer_seq #(
        .NUM_KERNELS (2),
        .TIMEOUT     (16'd8)
    ) dut0 (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready[0]),
        .busy       (busy[0]),
        .conv_start (conv_start[0]),
        .conv_done  (conv_done[0]),
        .pool_start (pool_start[0]),
        .pool_done  (pool_done[0]),
        .flat_start (flat_start[0]),
        .flat_done  (flat_done[0]),
        .kernel_sel (kernel_sel[0]),
        .csel       (csel[0]),
        .err        (err[0])
    );

    cnn_layer_seq #(
        .NUM_KERNELS (1),
        .TIMEOUT     (16'd0)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready[1]),
        .busy       (busy[1]),
        .conv_start (conv_start[1]),
        .conv_done  (conv_done[1]),
        .pool_start (pool_start[1]),
        .pool_done  (pool_done[1]),
        .flat_start (flat_start[1]),
        .flat_done  (flat_done[1]),
        .kernel_sel (kernel_sel[1]),
        .csel       (csel[1]),
        .err        (err[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observation vector: {busy, err, csel, kernel_sel, conv/pool/flat start}.
    function automatic logic [8:0] pack_obs(int d);
        return {busy[d], err[d], csel[d], kernel_sel[d],
                conv_start[d], pool_start[d], flat_start[d]};
    endfunction

    function automatic logic [8:0] exp_vec(logic b, logic e, logic [2:0] cs, logic ks,
                                           logic [2:0] st);
        return {b, e, cs, ks, st};
    endfunction

    // Memory select of a step: kind 0 conv, 1 pool, 2 flatten.
    function automatic logic [2:0] csel_of(int kind, int kern);
        if (kind == 0) return 3'(1 + kern);
        if (kind == 1) return 3'(3 + kern);
        return 3'd5;
    endfunction

    task automatic check(string tag, logic [8:0] obs, logic [8:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic clear_in(int d);
        ready[d]     = 1'b0;
        conv_done[d] = 1'b0;
        pool_done[d] = 1'b0;
        flat_done[d] = 1'b0;
    endtask

    task automatic drive_done(int d, logic [2:0] dn);
        conv_done[d] = dn[2];
        pool_done[d] = dn[1];
        flat_done[d] = dn[0];
    endtask

    // Idle cycles with stray done pulses, which must have no effect.
    task automatic idle_cycles(int d, int n);
        for (int c = 0; c < n; c++) begin
            ready[d] = 1'b0;
            drive_done(d, 3'($urandom_range(0, 7)));
            tick();
            check($sformatf("idle_d%0d_c%0d", d, c), pack_obs(d), 9'b0);
        end
        clear_in(d);
    endtask

    // One job on DUT d, entered from an observed IDLE cycle.
    // mode 0: complete job; mode 1: reset one cycle into step 'stop';
    // mode 2: withhold the done of step 'stop' until the watchdog fires.
    task automatic run_job(int d, int nk, int mode, int stop, bit hold);
        int kind[$];
        int kern[$];
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < nk; k++) begin
                kind.push_back(p);
                kern.push_back(k);
            end
        end
        kind.push_back(2);
        kern.push_back(0);

        check($sformatf("pre_idle_d%0d", d), pack_obs(d), 9'b0);
        ready[d] = 1'b1;
        drive_done(d, 3'b000);
        for (int i = 0; i < kind.size(); i++) begin
            int  last;
            bit  hold_off;
            hold_off = (mode == 2) && (i == stop);
            last     = hold_off ? 8 : lat[i];
            for (int k = 0; k <= last; k++) begin
                logic [2:0] st;
                logic [2:0] dn;
                tick();
                st = (k == 0) ? (3'b100 >> kind[i]) : 3'b000;
                check($sformatf("d%0d_step%0d_off%0d", d, i, k), pack_obs(d),
                      exp_vec(1'b1, 1'b0, csel_of(kind[i], kern[i]), kern[i] != 0, st));
                if (mode == 1 && i == stop && k == 1) begin
                    reset    = 1'b1;
                    ready[d] = 1'b1;
                    drive_done(d, 3'b100 >> kind[i]);
                    tick();
                    check($sformatf("d%0d_abort", d), pack_obs(d), 9'b0);
                    reset = 1'b0;
                    clear_in(d);
                    return;
                end
                ready[d] = 1'($urandom_range(0, 1));
                dn = 3'($urandom_range(0, 7));
                if (k != 0) dn[2 - kind[i]] = (k == last) && !hold_off;
                drive_done(d, dn);
            end
            if (hold_off) begin
                tick();
                check($sformatf("d%0d_err_entry", d), pack_obs(d),
                      exp_vec(1'b0, 1'b1, 3'b000, 1'b0, 3'b000));
                for (int c = 0; c < 4; c++) begin
                    ready[d] = 1'b1;
                    drive_done(d, 3'b111);
                    tick();
                    check($sformatf("d%0d_err_hold%0d", d, c), pack_obs(d),
                          exp_vec(1'b0, 1'b1, 3'b000, 1'b0, 3'b000));
                end
                reset = 1'b1;
                tick();
                check($sformatf("d%0d_err_reset", d), pack_obs(d), 9'b0);
                reset = 1'b0;
                clear_in(d);
                return;
            end
        end
        tick();
        check($sformatf("d%0d_done_cycle", d), pack_obs(d),
              exp_vec(1'b1, 1'b0, 3'b000, 1'b0, 3'b000));
        ready[d] = hold ? 1'b1 : 1'($urandom_range(0, 1));
        drive_done(d, 3'($urandom_range(0, 7)));
        tick();
        check($sformatf("d%0d_back_idle", d), pack_obs(d), 9'b0);
        clear_in(d);
    endtask

    initial begin
        reset = 1'b1;
        clear_in(0);
        clear_in(1);
        tick();
        tick();
        check("reset_d0", pack_obs(0), 9'b0);
        check("reset_d1", pack_obs(1), 9'b0);
        reset = 1'b0;
        idle_cycles(0, 2);

        // Nominal job, done three cycles after every start.
        lat = '{3, 3, 3, 3, 3};
        run_job(0, 2, 0, -1, 1'b0);
        idle_cycles(0, 3);

        // Minimum latency and done exactly at the watchdog limit.
        lat = '{1, 8, 1, 8, 8};
        run_job(0, 2, 0, -1, 1'b0);
        idle_cycles(0, 1);

        for (int j = 0; j < 4; j++) begin
            for (int s = 0; s < 5; s++) lat[s] = $urandom_range(1, 8);
            run_job(0, 2, 0, -1, 1'b0);
            idle_cycles(0, $urandom_range(0, 2));
        end

        // Back-to-back jobs with ready held through DONE.
        lat = '{2, 3, 4, 2, 1};
        run_job(0, 2, 0, -1, 1'b1);
        run_job(0, 2, 0, -1, 1'b0);

        // Single-kernel instance, including a wait far beyond 8 cycles.
        lat = '{3, 3, 3, 0, 0};
        run_job(1, 1, 0, -1, 1'b0);
        lat = '{2, 20, 1, 0, 0};
        run_job(1, 1, 0, -1, 1'b0);
        idle_cycles(1, 2);

        // Reset during POOL k1, then restart.
        lat = '{3, 3, 3, 5, 3};
        run_job(0, 2, 1, 3, 1'b0);
        lat = '{1, 2, 3, 4, 5};
        run_job(0, 2, 0, -1, 1'b0);

        // Watchdog expiry while waiting on POOL k0.
        lat = '{2, 4, 1, 1, 1};
        run_job(0, 2, 2, 2, 1'b0);
        idle_cycles(0, 2);
        lat = '{3, 3, 3, 3, 3};
        run_job(0, 2, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_layer_seq.md
CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

Interface
REQ-001 Parameter NUM_KERNELS, default 2: kernels sequenced per layer; legal values are 1 or 2.
REQ-002 Parameter TIMEOUT, default 16'd0: maximum cycles to wait for a step-done signal; 0 disables the watchdog.
REQ-003 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port ready  in  1: image available; sampled only in IDLE.
REQ-006 Port busy  out  1: job in progress.
REQ-007 Port conv_start  out  1: one-cycle start pulse to the convolution engine.
REQ-008 Port conv_done  in  1: one-cycle completion pulse from the convolution engine.
REQ-009 Port pool_start  out  1: one-cycle start pulse to the max-pool engine.
REQ-010 Port pool_done  in  1: one-cycle completion pulse from the max-pool engine.
REQ-011 Port flat_start  out  1: one-cycle start pulse to the flatten engine.
REQ-012 Port flat_done  in  1: one-cycle completion pulse from the flatten engine.
REQ-013 Port kernel_sel  out  1: active kernel index for the conv and pool steps.
REQ-014 Port csel  out  3: memory select (000 none; 001 L0K0; 010 L0K1; 011 L1K0; 100 L1K1; 101 L2).
REQ-015 Port err  out  1: watchdog fault, sticky until reset.

Function
REQ-016 States are IDLE, CONV, POOL, FLAT, DONE and ERR.
REQ-017 Step order shall be: CONV k0, CONV k1, POOL k0, POOL k1, FLAT, DONE; the k1 steps are skipped when NUM_KERNELS=1.
REQ-018 IDLE with ready=1 shall go to CONV, kernel_sel=0, on the next edge; busy is high from that edge.
REQ-019 ready shall be ignored outside IDLE.
REQ-020 On the first cycle of every step, exactly one of conv_start, pool_start or flat_start (matching the step) is high for exactly one cycle.
REQ-021 The matching done input is accepted from the cycle after the start pulse; a done input in the same cycle as its start is ignored.
REQ-022 An accepted done advances to the next step on the following edge, giving a 1-cycle done-to-next-start latency.
REQ-023 Non-matching done inputs, and any done input in IDLE, DONE or ERR, are ignored.
REQ-024 csel shall be 001/010 in CONV k0/k1, 011/100 in POOL k0/k1, 101 in FLAT, and 000 in IDLE, DONE and ERR.
REQ-025 kernel_sel equals the step's kernel index in CONV and POOL, and is 0 elsewhere.
REQ-026 DONE lasts exactly one cycle with busy still high, then goes to IDLE with busy low.
REQ-027 Back-to-back jobs are allowed: ready=1 in the first IDLE cycle starts the next job.
REQ-028 Watchdog: a 16-bit counter clears on each start pulse and increments each cycle spent waiting for done.
REQ-029 When TIMEOUT≠0 and the counter equals TIMEOUT with no accepted done, the next state is ERR.
REQ-030 If done arrives in the same cycle the counter reaches TIMEOUT, done wins and no error is raised.
REQ-031 ERR sets err=1, busy=0, csel=000 and drives all start outputs low; it is left only by reset.
REQ-032 The watchdog counter saturates at 16'hFFFF and does not wrap.

Reset
REQ-033 reset=1 at a rising edge shall force IDLE, busy=0, err=0, csel=000, kernel_sel=0, all start outputs 0, and the counter to 0.
REQ-034 reset in the middle of a job aborts the job immediately; no start pulse is issued in the cycle after reset.
REQ-035 reset has priority over every done input and over ready.

Structure
REQ-036 State encodings and csel codes are shared package constants; the CONV/MXPL SUB engines reuse these csel codes.
REQ-037 The watchdog is implemented as sub-module step_watchdog (inputs clr, en; output expired).
REQ-038 All outputs are registered; there is no combinational path from any input to any output.

Verification
REQ-039 Nominal run: ready=1; each done returned 3 cycles after its start -> start pulses in order conv,conv,pool,pool,flat; csel sequence 001,010,011,100,101,000; busy high for 5×4+1 cycles.
REQ-040 NUM_KERNELS=1 -> csel sequence is 001,011,101; exactly three start pulses are issued.
REQ-041 TIMEOUT=8 and pool_done withheld -> err=1 nine cycles after pool_start, busy=0, and ERR persists until reset.
REQ-042 conv_done in the same cycle as conv_start, and a stray flat_done during CONV -> both ignored; state unchanged.
REQ-043 reset asserted during POOL k1 -> next cycle shows IDLE outputs; a following ready=1 restarts at csel=001.
REQ-044 ready held high through DONE -> the second job's conv_start fires 2 cycles after the first job's DONE cycle.
